// File: rtl/monitor_bridge_pkg.sv
// monitor_bridge_pkg
// Shared definitions for the monitor memory bridge: FSM state encoding,
// command opcodes and the default status byte values.
// No ports (package).
package monitor_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_MEM_WR  = 3'd4,
    ST_MEM_RD  = 3'd5,
    ST_RD_WAIT = 3'd6,
    ST_RESP    = 3'd7
  } bridge_state_e;

  localparam logic [7:0] OP_WRITE     = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ      = 8'h52;  // 'R'
  localparam logic [7:0] OP_WRITE_INC = 8'h77;  // 'w'
  localparam logic [7:0] OP_READ_INC  = 8'h72;  // 'r'

  localparam logic [7:0] DEF_ACK_BYTE = 8'h4B;
  localparam logic [7:0] DEF_ERR_BYTE = 8'h3F;

  // States in which the bridge is willing to take a command byte.
  function automatic logic is_rx_state(bridge_state_e s);
    return (s == ST_IDLE) || (s == ST_ADDR_HI) || (s == ST_ADDR_LO) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/mon_tx_shifter.sv
// mon_tx_shifter
// Response byte shifter: loads either one status byte (in load_data[31:24])
// or a full 32-bit word, then presents it MSB byte first on a valid/ready
// byte stream.
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   load            load load_data this cycle (only used while idle)
//   load_data[31:0] word to send; single byte lives in [31:24]
//   load_four       1: send 4 bytes, 0: send 1 byte
//   tx_ready        downstream accepts tx_data
//   tx_data[7:0]    current byte (registered)
//   tx_valid        tx_data valid (registered)
//   last            final byte is transferring this cycle
module mon_tx_shifter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        load_four,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last
);

  logic [31:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load) begin
      shift_d = load_data;
      cnt_d   = load_four ? 3'd4 : 3'd1;
      valid_d = 1'b1;
    end else if (valid_q && tx_ready) begin
      shift_d = {shift_q[23:0], 8'h00};
      cnt_d   = cnt_q - 3'd1;
      valid_d = (cnt_q != 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q <= 32'h0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data  = shift_q[31:24];
  assign tx_valid = valid_q;
  assign last     = valid_q && tx_ready && (cnt_q == 3'd1);

endmodule

// File: rtl/monitor_mem_bridge.sv
// monitor_mem_bridge
// Parses 'W'/'R' command frames from the host byte link and drives the
// monitor's 8192 x 32 single-port memory; returns ACK/ERR status or read
// data on the outbound byte stream.
// Optional feature: define MON_BRIDGE_AUTOINC_EN to add the 'w'/'r'
// opcodes that use a post-incrementing internal address pointer.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   rx_data/valid/ready  inbound command bytes
//   tx_data/valid/ready  outbound response bytes
//   mem_*                memory address/control/write data, mem_readdata in
//   busy                 high whenever the FSM is not idle
//
// state      | meaning
// IDLE       | waiting for an opcode byte
// ADDR_HI    | expecting address MSB
// ADDR_LO    | expecting address LSB, range check
// DATA       | collecting D3..D0
// MEM_WR     | one-cycle write strobe
// MEM_RD     | one-cycle read strobe
// RD_WAIT    | memory returns data, loaded into the shifter
// RESP       | draining the response bytes
module monitor_mem_bridge
  import monitor_bridge_pkg::*;
#(
  parameter int         ADDR_W   = 13,
  parameter logic [7:0] ACK_BYTE = DEF_ACK_BYTE,
  parameter logic [7:0] ERR_BYTE = DEF_ERR_BYTE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy
);

  bridge_state_e state_q, state_d;

  logic [7:0]        addr_hi_q, addr_hi_d;
  logic              is_wr_q, is_wr_d;
  logic              oor_q, oor_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        cnt_q, cnt_d;
`ifdef MON_BRIDGE_AUTOINC_EN
  logic [ADDR_W-1:0] ptr_q, ptr_d;
`endif

  logic              rx_ready_q, rx_ready_d;
  logic              busy_q, busy_d;
  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [31:0]       mem_writedata_q, mem_writedata_d;
  logic              clken_q;

  logic        rx_fire;
  logic [15:0] addr16;
  logic        addr_oor;
  logic        sh_load, sh_load_four, sh_last;
  logic [31:0] sh_load_data;

  assign rx_fire  = rx_valid && rx_ready_q;
  assign addr16   = {addr_hi_q, rx_data};
  assign addr_oor = ((addr16 >> ADDR_W) != 16'd0);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and frame datapath
  always_comb begin
    state_d      = state_q;
    addr_hi_d    = addr_hi_q;
    is_wr_d      = is_wr_q;
    oor_d        = oor_q;
    tgt_d        = tgt_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
`ifdef MON_BRIDGE_AUTOINC_EN
    ptr_d        = ptr_q;
`endif
    sh_load      = 1'b0;
    sh_load_four = 1'b0;
    sh_load_data = 32'h0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          cnt_d = 2'd0;
          oor_d = 1'b0;
          case (rx_data)
            OP_WRITE: begin is_wr_d = 1'b1; state_d = ST_ADDR_HI; end
            OP_READ:  begin is_wr_d = 1'b0; state_d = ST_ADDR_HI; end
`ifdef MON_BRIDGE_AUTOINC_EN
            OP_WRITE_INC: begin is_wr_d = 1'b1; tgt_d = ptr_q; state_d = ST_DATA; end
            OP_READ_INC:  begin is_wr_d = 1'b0; tgt_d = ptr_q; state_d = ST_MEM_RD; end
`endif
            default: begin
              sh_load      = 1'b1;
              sh_load_data = {ERR_BYTE, 24'h0};
              state_d      = ST_RESP;
            end
          endcase
        end
      end
      ST_ADDR_HI: begin
        if (rx_fire) begin
          addr_hi_d = rx_data;
          state_d   = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (rx_fire) begin
          oor_d = addr_oor;
          tgt_d = addr16[ADDR_W-1:0];
`ifdef MON_BRIDGE_AUTOINC_EN
          if (!addr_oor) ptr_d = addr16[ADDR_W-1:0];
`endif
          if (is_wr_q) begin
            state_d = ST_DATA;
          end else if (addr_oor) begin
            sh_load      = 1'b1;
            sh_load_data = {ERR_BYTE, 24'h0};
            state_d      = ST_RESP;
          end else begin
            state_d = ST_MEM_RD;
          end
        end
      end
      ST_DATA: begin
        if (rx_fire) begin
          data_d = {data_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (oor_q) begin
              sh_load      = 1'b1;
              sh_load_data = {ERR_BYTE, 24'h0};
              state_d      = ST_RESP;
            end else begin
              state_d = ST_MEM_WR;
            end
          end
        end
      end
      ST_MEM_WR: begin
        sh_load      = 1'b1;
        sh_load_data = {ACK_BYTE, 24'h0};
`ifdef MON_BRIDGE_AUTOINC_EN
        ptr_d        = mem_address_q + 1'b1;
`endif
        state_d      = ST_RESP;
      end
      ST_MEM_RD: begin
`ifdef MON_BRIDGE_AUTOINC_EN
        ptr_d   = mem_address_q + 1'b1;
`endif
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        sh_load      = 1'b1;
        sh_load_four = 1'b1;
        sh_load_data = mem_readdata;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (sh_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up
  // with the state they describe.
  always_comb begin
    rx_ready_d      = is_rx_state(state_d);
    busy_d          = (state_d != ST_IDLE);
    cs_d            = (state_d == ST_MEM_WR) || (state_d == ST_MEM_RD);
    wr_d            = (state_d == ST_MEM_WR);
    mem_address_d   = cs_d ? tgt_d : mem_address_q;
    mem_writedata_d = wr_d ? data_d : mem_writedata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_hi_q       <= 8'h0;
      is_wr_q         <= 1'b0;
      oor_q           <= 1'b0;
      tgt_q           <= '0;
      data_q          <= 32'h0;
      cnt_q           <= 2'd0;
`ifdef MON_BRIDGE_AUTOINC_EN
      ptr_q           <= '0;
`endif
      rx_ready_q      <= 1'b0;
      busy_q          <= 1'b0;
      cs_q            <= 1'b0;
      wr_q            <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= 32'h0;
      clken_q         <= 1'b0;
    end else begin
      addr_hi_q       <= addr_hi_d;
      is_wr_q         <= is_wr_d;
      oor_q           <= oor_d;
      tgt_q           <= tgt_d;
      data_q          <= data_d;
      cnt_q           <= cnt_d;
`ifdef MON_BRIDGE_AUTOINC_EN
      ptr_q           <= ptr_d;
`endif
      rx_ready_q      <= rx_ready_d;
      busy_q          <= busy_d;
      cs_q            <= cs_d;
      wr_q            <= wr_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      clken_q         <= 1'b1;
    end
  end

  mon_tx_shifter u_tx_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (sh_load),
    .load_data (sh_load_data),
    .load_four (sh_load_four),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .last      (sh_last)
  );

  assign rx_ready       = rx_ready_q;
  assign busy           = busy_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = wr_q;
  assign mem_address    = mem_address_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_clken      = clken_q;
  assign mem_byteenable = 4'hF;

endmodule

// File: tb/tb_monitor_mem_bridge.sv
module tb_monitor_mem_bridge;

  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        rx_data = 8'h0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata = 32'h0;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  monitor_mem_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .busy           (busy)
  );

  // Memory model: unwritten words read back as {A5A5, address}.
  logic [31:0] mem [0:8191];
  bit          written [0:8191];
  int          cs_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      cs_cnt <= cs_cnt + 1;
      if (mem_write) begin
        mem[mem_address]     <= mem_writedata;
        written[mem_address] <= 1'b1;
        wr_cnt               <= wr_cnt + 1;
        last_wr_addr         <= 32'(mem_address);
        last_wr_data         <= mem_writedata;
      end else begin
        mem_readdata <= written[mem_address] ? mem[mem_address]
                                             : {16'hA5A5, 3'b000, mem_address};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (rx_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 rx_valid = 1'b0;
    check("rx_accept", 32'(ok), 32'd1);
  endtask

  task automatic recv_expect(input string tag, input logic [7:0] exp, input int stall);
    bit         ok = 0;
    bit         stable = 1;
    logic [7:0] b;
    @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      if (tx_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    check({tag, "_valid"}, 32'(ok), 32'd1);
    b = tx_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (tx_data !== b || tx_valid !== 1'b1 || busy !== 1'b1) stable = 0;
    end
    if (stall > 0) check({tag, "_stall_hold"}, 32'(stable), 32'd1);
    tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
    check(tag, 32'(b), 32'(exp));
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check(tag, 32'(busy), 32'd0);
  endtask

  int cs0, wr0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_write", 32'(mem_write), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_wdata", mem_writedata, 32'd0);
    check("rst_clken", 32'(mem_clken), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("byteenable", 32'(mem_byteenable), 32'hF);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_rx_ready", 32'(rx_ready), 32'd1);
    check("post_rst_clken", 32'(mem_clken), 32'd1);

    // Write 0x010 <= DEADBEEF with exact strobe timing
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    @(negedge clk);
    check("wr_cs", 32'(mem_chipselect), 32'd1);
    check("wr_strobe", 32'(mem_write), 32'd1);
    check("wr_addr", 32'(mem_address), 32'h010);
    check("wr_data", mem_writedata, 32'hDEADBEEF);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_rx_ready", 32'(rx_ready), 32'd0);
    check("wr_tx_early", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("wr_cs_one_cycle", 32'(mem_chipselect), 32'd0);
    check("ack_latency", 32'(tx_valid), 32'd1);
    recv_expect("wr_ack", 8'h4B, 0);
    expect_idle("wr_idle");
    check("wr_count", 32'(wr_cnt), 32'd1);
    check("wr_cs_count", 32'(cs_cnt), 32'd1);

    // Read back 0x010
    cs0 = cs_cnt; wr0 = wr_cnt;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    @(negedge clk);
    check("rd_cs", 32'(mem_chipselect), 32'd1);
    check("rd_write_low", 32'(mem_write), 32'd0);
    check("rd_addr", 32'(mem_address), 32'h010);
    recv_expect("rd_b3", 8'hDE, 0);
    recv_expect("rd_b2", 8'hAD, 0);
    recv_expect("rd_b1", 8'hBE, 0);
    recv_expect("rd_b0", 8'hEF, 0);
    expect_idle("rd_idle");
    check("rd_cs_count", 32'(cs_cnt - cs0), 32'd1);
    check("rd_no_write", 32'(wr_cnt - wr0), 32'd0);

    // Bad opcode and out-of-range accesses
    cs0 = cs_cnt;
    send_byte(8'h41);
    recv_expect("badop_err", 8'h3F, 0);
    expect_idle("badop_idle");
    send_byte(8'h52); send_byte(8'h20); send_byte(8'h00);
    recv_expect("rd_oor_err", 8'h3F, 0);
    send_byte(8'h57); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    recv_expect("wr_oor_err", 8'h3F, 0);
    expect_idle("oor_idle");
    check("oor_no_cs", 32'(cs_cnt - cs0), 32'd0);

    // Highest in-range word, unwritten
    send_byte(8'h52); send_byte(8'h1F); send_byte(8'hFF);
    recv_expect("rd_top_b3", 8'hA5, 0);
    recv_expect("rd_top_b2", 8'hA5, 0);
    recv_expect("rd_top_b1", 8'h1F, 0);
    recv_expect("rd_top_b0", 8'hFF, 0);

    // tx_ready stalled mid-response
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    recv_expect("stall_b3", 8'hDE, 0);
    recv_expect("stall_b2", 8'hAD, 5);
    recv_expect("stall_b1", 8'hBE, 0);
    recv_expect("stall_b0", 8'hEF, 0);
    expect_idle("stall_idle");

    // Reset mid-frame discards the partial write
    wr0 = wr_cnt;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h05); send_byte(8'hAA);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cs", 32'(mem_chipselect), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_rx_ready", 32'(rx_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("midrst_no_write", 32'(wr_cnt - wr0), 32'd0);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h05);
    recv_expect("midrst_rd_b3", 8'hA5, 0);
    recv_expect("midrst_rd_b2", 8'hA5, 0);
    recv_expect("midrst_rd_b1", 8'h00, 0);
    recv_expect("midrst_rd_b0", 8'h05, 0);
    expect_idle("midrst_idle");

`ifdef MON_BRIDGE_AUTOINC_EN
    send_byte(8'h57); send_byte(8'h1F); send_byte(8'hFF);
    send_byte(8'h11); send_byte(8'h11); send_byte(8'h11); send_byte(8'h11);
    recv_expect("inc_w_ack", 8'h4B, 0);
    check("inc_w_addr", last_wr_addr, 32'h1FFF);
    send_byte(8'h77);
    send_byte(8'h22); send_byte(8'h22); send_byte(8'h22); send_byte(8'h22);
    recv_expect("inc_wrap_ack", 8'h4B, 0);
    check("inc_wrap_addr", last_wr_addr, 32'h0000);
    check("inc_wrap_data", last_wr_data, 32'h22222222);
    send_byte(8'h72);
    recv_expect("inc_r_b3", 8'hA5, 0);
    recv_expect("inc_r_b2", 8'hA5, 0);
    recv_expect("inc_r_b1", 8'h00, 0);
    recv_expect("inc_r_b0", 8'h01, 0);
    expect_idle("inc_idle");
`else
    wr0 = wr_cnt; cs0 = cs_cnt;
    send_byte(8'h77);
    recv_expect("noinc_w_err", 8'h3F, 0);
    send_byte(8'h72);
    recv_expect("noinc_r_err", 8'h3F, 0);
    expect_idle("noinc_idle");
    check("noinc_no_cs", 32'(cs_cnt - cs0), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
